// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Final RV64 stage: MEM/WB register, 32x64 register file, ecall handshake and
// retired-instruction counter. Define WB_BYPASS_EN for write-first reads.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] STACK_INIT = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwb_valid,
  input  logic            memwb_wbactive,
  input  logic            memwb_dataselect,
  input  logic [XLEN-1:0] memwb_aluresult,
  input  logic [XLEN-1:0] memwb_loadeddata,
  input  logic [5:0]      memwb_rd,
  input  logic            memwb_ecall,
  output logic            wb_stall,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [4:0]      WBEX_rd,
  output logic [XLEN-1:0] WBEX_rdval,
  output logic            ecall_req,
  output logic [XLEN-1:0] ecall_a0,
  output logic [XLEN-1:0] ecall_a1,
  output logic [XLEN-1:0] ecall_a2,
  output logic [XLEN-1:0] ecall_a7,
  input  logic            ecall_ack,
  input  logic [XLEN-1:0] ecall_ret,
  output logic [63:0]     instret
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ECALL_REQ = 2'd1,
    ST_ECALL_WB  = 2'd2
  } wb_state_e;

  wb_state_e state_q, state_d;

  logic            wb_v_q, wb_v_d;
  logic            wb_wbactive_q, wb_wbactive_d;
  logic            wb_ecall_q, wb_ecall_d;
  logic [5:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;

  logic [XLEN-1:0] ecall_ret_q, ecall_ret_d;
  logic [XLEN-1:0] a0_q, a0_d;
  logic [XLEN-1:0] a1_q, a1_d;
  logic [XLEN-1:0] a2_q, a2_d;
  logic [XLEN-1:0] a7_q, a7_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic            capture;
  logic            wr_norm;
  logic            wr_ecall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  assign wb_stall = (state_q != ST_IDLE) || (wb_v_q && wb_ecall_q);
  assign capture  = memwb_valid && !wb_stall;

  // An ecall in the slot never writes rd; its only write is a0 from ECALL_WB.
  assign wr_norm  = wb_v_q && wb_wbactive_q && !wb_rd_q[5] &&
                    (wb_rd_q[4:0] != 5'd0) && !wb_ecall_q;
  assign wr_ecall = (state_q == ST_ECALL_WB);
  assign rf_we    = wr_norm || wr_ecall;
  assign rf_waddr = wr_ecall ? 5'd10 : wb_rd_q[4:0];
  assign rf_wdata = wr_ecall ? ecall_ret_q : wb_val_q;

  // MEM/WB register: slot valid for one cycle per capture
  always_comb begin
    wb_v_d        = capture;
    wb_wbactive_d = wb_wbactive_q;
    wb_ecall_d    = wb_ecall_q;
    wb_rd_d       = wb_rd_q;
    wb_val_d      = wb_val_q;
    if (capture) begin
      wb_wbactive_d = memwb_wbactive;
      wb_ecall_d    = memwb_ecall;
      wb_rd_d       = memwb_rd;
      wb_val_d      = memwb_dataselect ? memwb_loadeddata : memwb_aluresult;
    end
  end

  always_comb begin
    state_d     = state_q;
    ecall_ret_d = ecall_ret_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    a7_d        = a7_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_v_q && wb_ecall_q) begin
          state_d = ST_ECALL_REQ;
          a0_d    = rf_q[10];
          a1_d    = rf_q[11];
          a2_d    = rf_q[12];
          a7_d    = rf_q[17];
        end
      end
      ST_ECALL_REQ: begin
        if (ecall_ack) begin
          ecall_ret_d = ecall_ret;
          state_d     = ST_ECALL_WB;
        end
      end
      ST_ECALL_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Retires: any non-ecall slot instruction, or the ecall on its ECALL_WB exit
  always_comb begin
    instret_d = instret_q;
    if ((wb_v_q && !wb_ecall_q) || wr_ecall) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (rf_we) begin
      rf_d[rf_waddr] = rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wb_v_q        <= 1'b0;
      wb_wbactive_q <= 1'b0;
      wb_ecall_q    <= 1'b0;
      wb_rd_q       <= 6'd0;
      wb_val_q      <= {XLEN{1'b0}};
      ecall_ret_q   <= {XLEN{1'b0}};
      a0_q          <= {XLEN{1'b0}};
      a1_q          <= {XLEN{1'b0}};
      a2_q          <= {XLEN{1'b0}};
      a7_q          <= {XLEN{1'b0}};
      instret_q     <= 64'd0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= (i == 2) ? STACK_INIT : {XLEN{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      wb_v_q        <= wb_v_d;
      wb_wbactive_q <= wb_wbactive_d;
      wb_ecall_q    <= wb_ecall_d;
      wb_rd_q       <= wb_rd_d;
      wb_val_q      <= wb_val_d;
      ecall_ret_q   <= ecall_ret_d;
      a0_q          <= a0_d;
      a1_q          <= a1_d;
      a2_q          <= a2_d;
      a7_q          <= a7_d;
      instret_q     <= instret_d;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rs1_val = rf_q[rs1_idx];
    rs2_val = rf_q[rs2_idx];
    if (rf_we && (rf_waddr == rs1_idx)) rs1_val = rf_wdata;
    if (rf_we && (rf_waddr == rs2_idx)) rs2_val = rf_wdata;
    if (rs1_idx == 5'd0) rs1_val = {XLEN{1'b0}};
    if (rs2_idx == 5'd0) rs2_val = {XLEN{1'b0}};
  end
`else
  always_comb begin
    rs1_val = (rs1_idx == 5'd0) ? {XLEN{1'b0}} : rf_q[rs1_idx];
    rs2_val = (rs2_idx == 5'd0) ? {XLEN{1'b0}} : rf_q[rs2_idx];
  end
`endif

  assign WBEX_rd    = wr_norm ? wb_rd_q[4:0] : 5'd0;
  assign WBEX_rdval = wr_norm ? wb_val_q : {XLEN{1'b0}};
  assign ecall_req  = (state_q == ST_ECALL_REQ);
  assign ecall_a0   = a0_q;
  assign ecall_a1   = a1_q;
  assign ecall_a2   = a2_q;
  assign ecall_a7   = a7_q;
  assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Scoreboard bench for writeback_stage: directed scenarios plus random traffic.
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;

  localparam logic [63:0] SP_INIT = 64'h7FFF_F000;
  localparam int K_WRITE = 1;
  localparam int K_ECALL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwb_valid = 1'b0;
  logic        memwb_wbactive = 1'b0;
  logic        memwb_dataselect = 1'b0;
  logic [63:0] memwb_aluresult = '0;
  logic [63:0] memwb_loadeddata = '0;
  logic [5:0]  memwb_rd = '0;
  logic        memwb_ecall = 1'b0;
  logic        wb_stall;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rs2_idx = '0;
  logic [63:0] rs1_val, rs2_val;
  logic [4:0]  WBEX_rd;
  logic [63:0] WBEX_rdval;
  logic        ecall_req;
  logic [63:0] ecall_a0, ecall_a1, ecall_a2, ecall_a7;
  logic        ecall_ack = 1'b0;
  logic [63:0] ecall_ret = '0;
  logic [63:0] instret;

  writeback_stage #(.XLEN(64), .STACK_INIT(SP_INIT)) dut (
    .clk(clk), .reset(reset),
    .memwb_valid(memwb_valid), .memwb_wbactive(memwb_wbactive),
    .memwb_dataselect(memwb_dataselect), .memwb_aluresult(memwb_aluresult),
    .memwb_loadeddata(memwb_loadeddata), .memwb_rd(memwb_rd),
    .memwb_ecall(memwb_ecall), .wb_stall(wb_stall),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .WBEX_rd(WBEX_rd), .WBEX_rdval(WBEX_rdval),
    .ecall_req(ecall_req), .ecall_a0(ecall_a0), .ecall_a1(ecall_a1),
    .ecall_a2(ecall_a2), .ecall_a7(ecall_a7),
    .ecall_ack(ecall_ack), .ecall_ret(ecall_ret), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [63:0] val;
    logic [63:0] a0, a1, a2, a7;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_rf [32];
  logic [63:0] m_instret;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_rf[2] = SP_INIT;
    m_instret = '0;
    exp_q.delete();
  endtask

  // Returns at posedge+1, same phase as it was entered.
  task automatic do_reset();
    reset = 1'b1;
    memwb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Presents one instruction, holds it while stalled, updates the model once captured.
  task automatic issue(input logic wbact, input logic dsel, input logic [63:0] alu,
                       input logic [63:0] ld, input logic [5:0] rd, input logic ec);
    logic        cap;
    int          guard;
    logic [63:0] val;
    exp_t        e;
    memwb_valid = 1'b1;
    memwb_wbactive = wbact;
    memwb_dataselect = dsel;
    memwb_aluresult = alu;
    memwb_loadeddata = ld;
    memwb_rd = rd;
    memwb_ecall = ec;
    cap = 1'b0;
    guard = 0;
    while (!cap && guard < 50) begin
      @(negedge clk);
      cap = !wb_stall;
      @(posedge clk);
      #1;
      guard++;
    end
    memwb_valid = 1'b0;
    chk("capture_timeout", {63'd0, cap}, 64'd1);
    val = dsel ? ld : alu;
    e.kind = K_WRITE; e.rd = rd[4:0]; e.val = val;
    e.a0 = '0; e.a1 = '0; e.a2 = '0; e.a7 = '0;
    if (ec) begin
      e.kind = K_ECALL;
      e.a0 = m_rf[10]; e.a1 = m_rf[11]; e.a2 = m_rf[12]; e.a7 = m_rf[17];
      exp_q.push_back(e);
    end else begin
      m_instret++;
      if (wbact && !rd[5] && rd[4:0] != 5'd0) begin
        m_rf[rd[4:0]] = val;
        exp_q.push_back(e);
      end
    end
  endtask

  // Called right after the ecall capture edge; walks the handshake cycle by cycle.
  task automatic ecall_service(input logic [63:0] ret, input int delay);
    ecall_ack = 1'b0;
    @(negedge clk);
    chk("ecall_req_e0", {63'd0, ecall_req}, 64'd0);
    chk("stall_e0", {63'd0, wb_stall}, 64'd1);
    @(posedge clk); #1;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("ecall_req_hold", {63'd0, ecall_req}, 64'd1);
      chk("stall_hold", {63'd0, wb_stall}, 64'd1);
      @(posedge clk); #1;
    end
    ecall_ack = 1'b1;
    ecall_ret = ret;
    @(negedge clk);
    chk("ecall_req_ack", {63'd0, ecall_req}, 64'd1);
    @(posedge clk); #1;
    ecall_ack = 1'b0;
    ecall_ret = $urandom();
    @(negedge clk);
    chk("ecall_req_wb", {63'd0, ecall_req}, 64'd0);
    chk("stall_wb", {63'd0, wb_stall}, 64'd1);
    @(posedge clk); #1;
    m_rf[10] = ret;
    m_instret++;
    rs2_idx = 5'd10;
    @(negedge clk);
    chk("x10_after_ecall", rs2_val, ret);
    chk("stall_clear", {63'd0, wb_stall}, 64'd0);
    chk("instret_ecall", instret, m_instret);
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected responses whenever the DUT presents a write or raises an ecall.
  initial begin
    logic prev_req;
    exp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (WBEX_rd != 5'd0) begin
          if (exp_q.size() == 0) begin
            chk("wbex_unexpected", {59'd0, WBEX_rd}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wbex_kind", 64'(e.kind), 64'(K_WRITE));
            chk("wbex_rd", {59'd0, WBEX_rd}, {59'd0, e.rd});
            chk("wbex_rdval", WBEX_rdval, e.val);
          end
        end
        if (ecall_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            chk("ecall_unexpected", {63'd0, ecall_req}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ecall_kind", 64'(e.kind), 64'(K_ECALL));
            chk("ecall_a0", ecall_a0, e.a0);
            chk("ecall_a1", ecall_a1, e.a1);
            chk("ecall_a2", ecall_a2, e.a2);
            chk("ecall_a7", ecall_a7, e.a7);
            chk("ecall_stall", {63'd0, wb_stall}, 64'd1);
          end
        end
      end
      prev_req = ecall_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old9;
    logic [63:0] r;
    int          k;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rs1_idx = 5'd2;
    rs2_idx = 5'd5;
    @(negedge clk);
    chk("rst_x2", rs1_val, SP_INIT);
    chk("rst_x5", rs2_val, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_stall", {63'd0, wb_stall}, 64'd0);
    chk("rst_ecall_req", {63'd0, ecall_req}, 64'd0);
    chk("rst_wbex_rd", {59'd0, WBEX_rd}, 64'd0);
    chk("rst_wbex_rdval", WBEX_rdval, 64'd0);
    chk("rst_a0", ecall_a0, 64'd0);
    chk("rst_a7", ecall_a7, 64'd0);
    @(posedge clk); #1;

    // ALU write to x5
    issue(1'b1, 1'b0, 64'h1234, 64'hDEAD, 6'd5, 1'b0);
    @(posedge clk); #1;
    rs1_idx = 5'd5;
    @(negedge clk);
    chk("x5_alu", rs1_val, 64'h1234);
    chk("instret_1", instret, 64'd1);
    chk("wbex_idle", {59'd0, WBEX_rd}, 64'd0);
    @(posedge clk); #1;

    // Load write to x7, then write to x0 which is dropped
    issue(1'b1, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FF80, 6'd7, 1'b0);
    issue(1'b1, 1'b0, 64'h55, 64'h0, 6'd0, 1'b0);
    @(posedge clk); #1;
    rs1_idx = 5'd7;
    rs2_idx = 5'd0;
    @(negedge clk);
    chk("x7_load", rs1_val, 64'hFFFF_FFFF_FFFF_FF80);
    chk("x0_zero", rs2_val, 64'd0);
    chk("instret_3", instret, m_instret);
    @(posedge clk); #1;

    // Ecall with a7=93, a0=3, ack after 5 cycles
    issue(1'b1, 1'b0, 64'd93, 64'd0, 6'd17, 1'b0);
    issue(1'b1, 1'b0, 64'd3, 64'd0, 6'd10, 1'b0);
    issue(1'b1, 1'b0, 64'd0, 64'd0, 6'd10, 1'b1);
    ecall_service(64'h2A, 5);

    // Same-cycle read of a pending write to x9
    old9 = m_rf[9];
    issue(1'b1, 1'b0, 64'hABCD, 64'd0, 6'd9, 1'b0);
    rs1_idx = 5'd9;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("x9_bypass", rs1_val, 64'hABCD);
`else
    chk("x9_no_bypass", rs1_val, old9);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("x9_after_e1", rs1_val, 64'hABCD);
    @(posedge clk); #1;

    // Reset during ECALL_REQ, with a simultaneous ack that must be overridden
    issue(1'b1, 1'b0, 64'h77, 64'd0, 6'd10, 1'b0);
    issue(1'b0, 1'b0, 64'd0, 64'd0, 6'd0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ecall_req_before_rst", {63'd0, ecall_req}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    ecall_ack = 1'b1;
    ecall_ret = 64'h99;
    @(posedge clk); #1;
    reset = 1'b0;
    ecall_ack = 1'b0;
    model_reset();
    rs1_idx = 5'd10;
    rs2_idx = 5'd2;
    @(negedge clk);
    chk("rst_mid_ecall_req", {63'd0, ecall_req}, 64'd0);
    chk("rst_mid_stall", {63'd0, wb_stall}, 64'd0);
    chk("rst_mid_x10", rs1_val, 64'd0);
    chk("rst_mid_x2", rs2_val, SP_INIT);
    chk("rst_mid_instret", instret, 64'd0);
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      ecall_ack = ($urandom_range(0, 3) == 0);
      ecall_ret = {$urandom(), $urandom()};
      rs1_idx = 5'($urandom());
      rs2_idx = 5'($urandom());
      r = {$urandom(), $urandom()};
      case (k)
        6: issue(1'b0, 1'($urandom()), r, {$urandom(), $urandom()}, 6'($urandom()), 1'b0);
        7: issue(1'b1, 1'($urandom()), r, {$urandom(), $urandom()},
                 {1'b1, 5'($urandom())}, 1'b0);
        8: begin
          issue(1'($urandom()), 1'($urandom()), r, {$urandom(), $urandom()},
                6'($urandom()), 1'b1);
          ecall_service({$urandom(), $urandom()}, $urandom_range(0, 5));
        end
        default: issue(1'b1, 1'($urandom()), r, {$urandom(), $urandom()},
                       {1'b0, 5'($urandom())}, 1'b0);
      endcase
      ecall_ack = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Drain and compare architectural state with the model
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("instret_final", instret, m_instret);
    for (int i = 0; i < 32; i++) begin
      rs1_idx = 5'(i);
      rs2_idx = 5'(31 - i);
      #1;
      chk($sformatf("rf_rs1_x%0d", i), rs1_val, m_rf[i]);
      chk($sformatf("rf_rs2_x%0d", 31 - i), rs2_val, m_rf[31 - i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC-V core, directly downstream of the memory stage. It captures the memory-stage result (ALU result or loaded data, destination register, writeback-enable, ecall flag) into the MEM/WB register. It owns the 32×64 integer register file and serves the decode stage's two read ports. It also provides a forwarding path to execute, sequences system calls through a request/acknowledge handshake, and counts retired instructions.

## Interface
- XLEN, 64, datapath width
- STACK_INIT, 64'h0, reset value of x2 (sp)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- memwb_valid  in  1  memory stage presents a completed instruction this cycle
- memwb_wbactive  in  1  instruction writes rd
- memwb_dataselect  in  1  0: use memwb_aluresult, 1: use memwb_loadeddata
- memwb_aluresult  in  XLEN  ALU result
- memwb_loadeddata  in  XLEN  load data, already extended
- memwb_rd  in  6  destination; bits [4:0] index, bit 5 set suppresses the write
- memwb_ecall  in  1  instruction is ECALL
- wb_stall  out  1  stage cannot accept; memory stage must hold
- rs1_idx, rs2_idx  in  5 each  decode read addresses
- rs1_val, rs2_val  out  XLEN each  read data; x0 always reads 0
- WBEX_rd  out  5  rd of the captured instruction, 0 if no write pending
- WBEX_rdval  out  XLEN  value to be written
- ecall_req  out  1  system call pending
- ecall_a0, ecall_a1, ecall_a2, ecall_a7  out  XLEN each  x10, x11, x12, x17 snapshots
- ecall_ack  in  1  system call complete
- ecall_ret  in  XLEN  value for a0
- instret  out  64  retired-instruction count

## Operation
- MEM/WB register: captures at posedge when memwb_valid && !wb_stall. The result value is muxed by memwb_dataselect at capture.
- The captured slot (wb_v) is valid for exactly one cycle, then clears unless a new capture occurs.
- Register write at the edge after capture when wb_v && wbactive && rd[5]==0 && rd[4:0]!=0 && !ecall. Writes to x0 are dropped.
- Reads are combinational from the array.
- FSM states: IDLE, ECALL_REQ, ECALL_WB.
  - IDLE → ECALL_REQ when wb_v && ecall. No register write occurs. The a0/a1/a2/a7 snapshots are latched on the same edge.
  - ECALL_REQ: ecall_req=1, held stable until ecall_ack=1. On the ack edge, ecall_ret is latched and the FSM goes to ECALL_WB.
  - ECALL_WB: writes x10 = latched ecall_ret, then returns to IDLE.
- wb_stall = (state != IDLE) || (wb_v && ecall). Upstream is therefore frozen from the cycle after the ecall is captured until IDLE is re-entered.
- ecall_ack seen outside ECALL_REQ is ignored.
- instret increments by 1 on the edge that retires an instruction: a normal write, a non-writing instruction, or the ECALL_WB exit. Increments are 64-bit wrapping.
- WBEX_rd/WBEX_rdval reflect the pending write while wb_v and a write is qualified; otherwise WBEX_rd=0.

## Timing
- Reset values:
  - state=IDLE, wb_v=0, wb_stall=0, ecall_req=0, instret=0, WBEX_rd=0, WBEX_rdval=0, ecall_a*=0.
  - All registers are 0 except x2=STACK_INIT.
- Reset has priority over every event, including mid-ecall: ecall_req drops on the next edge and no a0 write occurs.
- Latency:
  - Capture edge E0.
  - Register-file update at E1.
  - Value readable via rs*_val from E1, or via the bypass during E0–E1 (see Configuration).
- Ecall: ecall_req asserts the cycle after E1 and remains asserted until ack. x10 is updated one edge after the ack edge, and wb_stall deasserts the cycle after that.
- Back-to-back instructions: one capture per cycle, no bubbles when there is no ecall.
- memwb_valid while wb_stall=1 is not captured; upstream must hold it.

## Configuration
- WB_BYPASS_EN defined: when rs1_idx/rs2_idx equals a qualified pending write rd (including the ECALL_WB write to x10), rs*_val returns the write data in the same cycle (write-first). Index 0 always returns 0.
- Undefined: reads return array contents only. Decode must tolerate the one-cycle-old value, or stall/forward via WBEX_*.

## Test plan
- Reset with STACK_INIT=64'h7FFF_F000 → rs1_idx=2 reads 64'h7FFF_F000, rs2_idx=5 reads 0, instret=0.
- Capture ALU write rd=5, aluresult=64'h1234, dataselect=0 → WBEX_rd=5 for one cycle, x5=64'h1234 after E1, instret=1.
- Load write rd=7, dataselect=1, loadeddata=64'hFFFF_FFFF_FFFF_FF80, aluresult=64'h10 → x7=64'hFFFF_FFFF_FFFF_FF80. Then rd=0 with value 64'h55 → x0 still reads 0.
- Ecall with x17=93, x10=3 → ecall_req=1 with ecall_a7=93, ecall_a0=3, wb_stall=1. Hold ack low 5 cycles, then ack with ret=64'h2A → x10=64'h2A, wb_stall clears, instret +1.
- Assert reset while in ECALL_REQ → ecall_req=0 and state IDLE after the edge, x10=0.
- With WB_BYPASS_EN, capture rd=9 value 64'hABCD and drive rs1_idx=9 in the same cycle → rs1_val=64'hABCD before E1. Without the macro → old value (0).
